// File: rtl/subservient_pkg.sv
// Shared definitions for the subservient UART transmitter: FSM encoding,
// status register bit positions and the baud divisor helper.
package subservient_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // Bit positions inside the 8-bit status register
  localparam logic [2:0] StatBusy  = 3'd0;
  localparam logic [2:0] StatFull  = 3'd1;
  localparam logic [2:0] StatEmpty = 3'd2;
  localparam logic [2:0] StatOvf   = 3'd3;

  // Clock cycles per serial bit, rounded to nearest
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/subservient_fifo.sv
// Small synchronous FIFO with extra-MSB pointers for full/empty detection.
// The caller guarantees no push when full unless a pop happens in the same cycle.
module subservient_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem [Depth];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;

  // Pointer update; pointers wrap naturally modulo 2^(AW+1)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; a push into the slot being popped is safe since the head
  // is consumed from rdata in the same cycle
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/subservient_uart_tx.sv
// Wishbone-attached UART transmitter with a small transmit FIFO.
// Bus requests are registered and acted on in the ack cycle, so o_q is only
// ever driven from registered state.
module subservient_uart_tx
  import subservient_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 57600,
  parameter int unsigned FIFO_AW  = 2
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  input  logic       i_wb_adr,
  input  logic [7:0] i_wb_dat,
  input  logic       i_wb_we,
  input  logic       i_wb_stb,
  output logic [7:0] o_wb_rdt,
  output logic       o_wb_ack,
  output logic       o_q
);

  localparam int unsigned Div     = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CntW    = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(Div - 1);

  // Bus side
  logic       ack_q;
  logic [7:0] rdt_q;
  logic       req_we_q;
  logic       req_adr_q;
  logic [7:0] req_dat_q;
  logic       ovf_q;
  logic       bus_req;
  logic       wr_req;
  logic       stat_clr;
  logic [7:0] status;

  // FIFO side
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [7:0] fifo_rdata;

  // Transmit FSM
  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            q_q, q_d;
  logic            busy;

  assign bus_req  = i_wb_stb & ~ack_q;
  assign wr_req   = ack_q & req_we_q & ~req_adr_q;
  assign stat_clr = ack_q & ~req_we_q & req_adr_q;
  // A full FIFO still takes the byte when the FSM pops in the same cycle
  assign push     = wr_req & (~full | pop);
  assign busy     = (state_q != StIdle) | ~empty;

  // Status register image
  always_comb begin
    status            = '0;
    status[StatBusy]  = busy;
    status[StatFull]  = full;
    status[StatEmpty] = empty;
    status[StatOvf]   = ovf_q;
  end

  // Bus handshake: ack one cycle after a request, latch request fields
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_q     <= 1'b0;
      rdt_q     <= 8'h00;
      req_we_q  <= 1'b0;
      req_adr_q <= 1'b0;
      req_dat_q <= 8'h00;
    end else begin
      ack_q <= bus_req;
      if (bus_req) begin
        req_we_q  <= i_wb_we;
        req_adr_q <= i_wb_adr;
        req_dat_q <= i_wb_dat;
        rdt_q     <= (!i_wb_we && i_wb_adr) ? status : 8'h00;
      end
    end
  end

  // Sticky overflow flag, cleared when a status read completes
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ovf_q <= 1'b0;
    end else if (wr_req && full && !pop) begin
      ovf_q <= 1'b1;
    end else if (stat_clr) begin
      ovf_q <= 1'b0;
    end
  end

  subservient_fifo #(
    .DW (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .push  (push),
    .wdata (req_dat_q),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  // Transmit FSM state register; o_q is registered from the next state
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      q_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      q_q     <= q_d;
    end
  end

  // Transmit FSM next-state: each state lasts Div cycles (cnt counts down)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    q_d     = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          cnt_d   = CntLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          cnt_d   = CntLoad;
          bit_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          cnt_d   = CntLoad;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          // Chain straight into the next frame to avoid an idle gap
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            cnt_d   = CntLoad;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    case (state_d)
      StStart: q_d = 1'b0;
      StData:  q_d = shift_d[0];
      default: q_d = 1'b1;
    endcase
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_q      = q_q;

endmodule
